// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: signed 8x8 -> signed 16, one iteration per cycle.
// Includes the eight_bit_addsub stage that forms each partial-sum step.

module eight_bit_addsub (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       opcode,
    output logic [7:0] res,
    output logic       overflow
);
    logic [7:0] w_b_eff;

    // opcode=1 computes a-b as a + ~b + 1
    assign w_b_eff  = opcode ? ~b : b;
    assign res      = a + w_b_eff + {7'd0, opcode};
    assign overflow = (a[7] == w_b_eff[7]) && (res[7] != a[7]);
endmodule

module booth_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_a, w_a_nxt;
    logic [7:0]  r_q, w_q_nxt;
    logic        r_qm1, w_qm1_nxt;
    logic [7:0]  r_m, w_m_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_product, w_product_nxt;

    logic [1:0]  w_booth;
    logic        w_opcode;
    logic [7:0]  w_res;
    logic        w_ovf;
    logic [7:0]  w_s;
    logic        w_t;

    assign w_booth  = {r_q[0], r_qm1};
    assign w_opcode = (w_booth == 2'b10);

    eight_bit_addsub u_addsub (
        .a        (r_a),
        .b        (r_m),
        .opcode   (w_opcode),
        .res      (w_res),
        .overflow (w_ovf)
    );

    // The true sign of A+-M is res[7]^overflow; this keeps M=-128 correct.
    always_comb begin
        w_s = r_a;
        w_t = r_a[7];
        if (w_booth == 2'b01 || w_booth == 2'b10) begin
            w_s = w_res;
            w_t = w_res[7] ^ w_ovf;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_q_nxt       = r_q;
        w_qm1_nxt     = r_qm1;
        w_m_nxt       = r_m;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = 8'd0;
                    w_q_nxt     = multiplier;
                    w_qm1_nxt   = 1'b0;
                    w_m_nxt     = multiplicand;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt   = {w_t, w_s[7:1]};
                w_q_nxt   = {w_s[0], r_q[7:1]};
                w_qm1_nxt = r_q[0];
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd7) begin
                    w_state_nxt   = S_DONE;
                    w_product_nxt = {w_t, w_s[7:1], w_s[0], r_q[7:1]};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= 8'd0;
            r_q       <= 8'd0;
            r_qm1     <= 1'b0;
            r_m       <= 8'd0;
            r_cnt     <= 4'd0;
            r_product <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_q       <= w_q_nxt;
            r_qm1     <= w_qm1_nxt;
            r_m       <= w_m_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign product = r_product;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
endmodule
